pu_recv: RTL and testbench

PU_RECV -- requirements
Module: pu_recv

---
 rtl/pu_pkg.sv | 25 ++
 rtl/pu_recv.sv | 140 ++++++++++++++
 tb/tb_pu_recv.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pu_pkg.sv
// pu_pkg: definitions shared by the PU receive path.
//   - Header beat field positions inside the 16-bit in_data word.
//   - Port-number width.
//   - Receiver state encoding.
package pu_pkg;

    // Header beat layout: {addr[15:8], size[7:0]}
    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 8;
    localparam int SIZE_MSB = 7;
    localparam int SIZE_LSB = 0;

    // Payload count width; it follows the size field, so a transfer is at most 255 words.
    localparam int CNT_W  = SIZE_MSB - SIZE_LSB + 1;

    localparam int PORT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2,
        ST_FIN  = 2'd3
    } pu_state_t;

endpackage

// File: rtl/pu_recv.sv
// pu_recv: one receive port of the PU.
// A transfer is one header beat {addr, size} followed by 'size' payload words.
// When the header names PORT_ID, the payload is written to data memory at
// consecutive addresses. Otherwise the payload is consumed and discarded.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   in_valid/in_ready beat handshake; a beat transfers when both are high
//   in_port           destination port, looked at only on the header beat
//   in_data           header beat, then payload words
//   dm_busy           PU owns the data-memory write port this cycle
//   dm_we/addr/wd     registered data-memory write, one cycle after the beat
//   busy              transfer in progress (any state but IDLE)
//   done / dropped    one-cycle end-of-transfer pulse (own / foreign port)
module pu_recv
    import pu_pkg::*;
#(
    parameter logic [PORT_W-1:0] PORT_ID = 4'd0,
    parameter int                AW      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PORT_W-1:0] in_port,
    input  logic [15:0]       in_data,
    input  logic              dm_busy,
    output logic              dm_we,
    output logic [AW-1:0]     dm_addr,
    output logic [15:0]       dm_wd,
    output logic              busy,
    output logic              done,
    output logic              dropped
);

    pu_state_t        state_reg, state_next;
    logic [AW-1:0]    addr_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic             own_reg;

    logic             xfer;
    logic [CNT_W-1:0] hdr_size;
    logic [AW-1:0]    hdr_addr;
    logic             hdr_own;

    assign hdr_size = in_data[SIZE_MSB:SIZE_LSB];
    assign hdr_addr = AW'(in_data[ADDR_MSB:ADDR_LSB]);
    assign hdr_own  = (in_port == PORT_ID);
    assign xfer     = in_valid && in_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (hdr_size == '0) begin
                        state_next = ST_FIN;
                    end else if (hdr_own) begin
                        state_next = ST_DATA;
                    end else begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_DATA: begin
                // Only accept a beat when the write port will be free to take it.
                in_ready = ~dm_busy;
                if (in_valid && !dm_busy && remaining_reg == CNT_W'(1)) begin
                    state_next = ST_FIN;
                end
            end
            ST_DROP: begin
                // Discarded beats never touch memory, so dm_busy is irrelevant here.
                in_ready = 1'b1;
                if (in_valid && remaining_reg == CNT_W'(1)) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address / count tracking and the registered memory write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            own_reg       <= 1'b0;
            dm_we         <= 1'b0;
            dm_addr       <= '0;
            dm_wd         <= '0;
        end else begin
            dm_we <= (state_reg == ST_DATA) && xfer;

            if (state_reg == ST_IDLE && xfer) begin
                addr_reg      <= hdr_addr;
                remaining_reg <= hdr_size;
                own_reg       <= hdr_own;
            end else if ((state_reg == ST_DATA || state_reg == ST_DROP) && xfer) begin
                // Address wraps naturally at 2^AW.
                addr_reg      <= addr_reg + AW'(1);
                remaining_reg <= remaining_reg - CNT_W'(1);
            end

            if (state_reg == ST_DATA && xfer) begin
                dm_addr <= addr_reg;
                dm_wd   <= in_data;
            end
        end
    end

    // own_reg also covers size-0 headers, which go straight from IDLE to FIN.
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_FIN) &&  own_reg;
    assign dropped = (state_reg == ST_FIN) && !own_reg;

endmodule

// File: tb/tb_pu_recv.sv
// Testbench for pu_recv (PORT_ID=2, AW=8).
// The stimulus tasks know each transfer they send. From the transfer rules they
// derive the expected write list (address, data, cycle), the cycle of the
// end-of-transfer pulse, and the busy window. One negedge process compares
// the DUT against those expectations every cycle. Directed cases pin literal
// write values.
module tb_pu_recv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_port = 4'd0;
    logic [15:0] in_data = 16'd0;
    logic        dm_busy = 1'b0;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [15:0] dm_wd;
    logic        busy;
    logic        done;
    logic        dropped;

    always #5 clk = ~clk;

    pu_recv #(.PORT_ID(4'd2), .AW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_port  (in_port),
        .in_data  (in_data),
        .dm_busy  (dm_busy),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wd    (dm_wd),
        .busy     (busy),
        .done     (done),
        .dropped  (dropped)
    );

    typedef struct {
        int          cyc;
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    wr_t         wq[$];
    int          done_q[$];
    int          drop_q[$];
    logic [23:0] wlog[$];
    int          n_done_seen = 0;
    int          n_drop_seen = 0;
    int          hdr_cyc = -10;
    int          fin_cyc = -10;
    bit          cur_own = 1'b0;
    bit          busy_force = 1'b0;
    bit          busy_rand = 1'b0;
    int          stall_wait = 0;
    logic [15:0] fixed_pay[4];

    always @(posedge clk) cyc <= cyc + 1;

    // Background dm_busy driver
    initial begin
        forever begin
            @(posedge clk);
            #2;
            dm_busy = busy_force || (busy_rand && ($urandom_range(0, 3) == 0));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pin(input string name, input int idx, input logic [23:0] exp);
        if (idx < wlog.size()) begin
            chk(name, wlog[idx], exp);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no write #%0d, want %0h", name, idx, exp);
        end
    endtask

    // Per-cycle compare against the scoreboard
    always @(negedge clk) begin
        bit  e_busy, e_ready, e_done, e_drop, e_we;
        wr_t w;
        if (rst_n) begin
            e_busy  = (cyc > hdr_cyc) && (cyc <= fin_cyc);
            e_ready = (cyc == fin_cyc) ? 1'b0 :
                      (e_busy && cur_own && dm_busy) ? 1'b0 : 1'b1;
            chk("busy", busy, e_busy);
            chk("in_ready", in_ready, e_ready);

            e_done = (done_q.size() > 0) && (done_q[0] == cyc);
            if (e_done) void'(done_q.pop_front());
            chk("done", done, e_done);
            if (done) n_done_seen++;

            e_drop = (drop_q.size() > 0) && (drop_q[0] == cyc);
            if (e_drop) void'(drop_q.pop_front());
            chk("dropped", dropped, e_drop);
            if (dropped) n_drop_seen++;

            e_we = (wq.size() > 0) && (wq[0].cyc == cyc);
            chk("dm_we", dm_we, e_we);
            if (e_we) begin
                w = wq.pop_front();
                chk("dm_addr", dm_addr, w.a);
                chk("dm_wd", dm_wd, w.d);
            end
            if (dm_we) wlog.push_back({dm_addr, dm_wd});
            $display("cyc %0d: rdy=%0b busy=%0b we=%0b a=%02h d=%04h done=%0b drop=%0b",
                     cyc, in_ready, busy, dm_we, dm_addr, dm_wd, done, dropped);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int gap_max);
        int n;
        n = $urandom_range(0, gap_max);
        repeat (n) begin
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            in_port  = 4'($urandom);
            step();
        end
    endtask

    // Present one beat and hold it until accepted; returns the handshake cycle.
    task automatic beat(input logic [15:0] d, input logic [3:0] p, input int stall,
                        output int hc);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_port  = p;
        if (stall > 0) busy_force = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited == stall) busy_force = 1'b0;
            if (waited > 40) begin
                n_cmp++;
                n_bad++;
                $display("FAIL hs_timeout: got no handshake in %0d cycles, want one", waited);
                break;
            end
        end
        if (stall > 0) stall_wait = waited;
        busy_force = 1'b0;
        hc = cyc;
        step();
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_port  = 4'($urandom);
    endtask

    task automatic push_end(input bit own, input int c);
        if (own) done_q.push_back(c);
        else     drop_q.push_back(c);
    endtask

    task automatic xfer(input logic [7:0] addr, input logic [7:0] size, input logic [3:0] port,
                        input int gap_max, input bit fixed, input int stall_beat,
                        output int hc);
        int          c;
        logic [15:0] d;
        bit          own;
        own = (port == 4'd2);
        idle_gap(gap_max);
        beat({addr, size}, port, 0, c);
        hc      = c;
        hdr_cyc = c;
        cur_own = own;
        fin_cyc = (size == 8'd0) ? c + 1 : (1 << 30);
        if (size == 8'd0) begin
            push_end(own, c + 1);
        end else begin
            for (int i = 0; i < int'(size); i++) begin
                idle_gap(gap_max);
                d = fixed ? fixed_pay[i % 4] : 16'($urandom);
                beat(d, 4'($urandom), (i == stall_beat) ? 3 : 0, c);
                if (own) wq.push_back('{c + 1, addr + 8'(i), d});
                if (i == int'(size) - 1) begin
                    fin_cyc = c + 1;
                    push_end(own, c + 1);
                end
            end
        end
    endtask

    initial begin
        int hc1, hc2, c, d0, p0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dm_we", dm_we, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_dm_wd", dm_wd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dropped", dropped, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        step();

        // Own-port transfer, three words
        fixed_pay = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0000};
        wlog.delete();
        d0 = n_done_seen;
        xfer(8'h10, 8'd3, 4'd2, 0, 1'b1, -1, hc1);
        repeat (2) step();
        chk("r032_nwr", wlog.size(), 3);
        pin("r032_w0", 0, 24'h10AAAA);
        pin("r032_w1", 1, 24'h11BBBB);
        pin("r032_w2", 2, 24'h12CCCC);
        chk("r032_done", n_done_seen - d0, 1);

        // Address wrap
        fixed_pay = '{16'h1111, 16'h2222, 16'h3333, 16'h0000};
        wlog.delete();
        d0 = n_done_seen;
        xfer(8'hFE, 8'd3, 4'd2, 0, 1'b1, -1, hc1);
        repeat (2) step();
        pin("r033_w0", 0, 24'hFE1111);
        pin("r033_w1", 1, 24'hFF2222);
        pin("r033_w2", 2, 24'h003333);
        chk("r033_done", n_done_seen - d0, 1);

        // Foreign port: consumed, never written
        wlog.delete();
        d0 = n_done_seen;
        p0 = n_drop_seen;
        busy_rand = 1'b1;
        xfer(8'h20, 8'd2, 4'd5, 0, 1'b0, -1, hc1);
        busy_rand = 1'b0;
        repeat (2) step();
        chk("r034_nwr", wlog.size(), 0);
        chk("r034_dropped", n_drop_seen - p0, 1);
        chk("r034_done", n_done_seen - d0, 0);

        // Size-0 header, then a header back to back
        wlog.delete();
        d0 = n_done_seen;
        xfer(8'h30, 8'd0, 4'd2, 0, 1'b0, -1, hc1);
        fixed_pay = '{16'h5A5A, 16'h0000, 16'h0000, 16'h0000};
        xfer(8'h31, 8'd1, 4'd2, 0, 1'b1, -1, hc2);
        repeat (2) step();
        chk("r035_hdr_gap", hc2 - hc1, 2);
        chk("r035_nwr", wlog.size(), 1);
        pin("r035_w0", 0, 24'h315A5A);
        chk("r035_done", n_done_seen - d0, 2);

        // dm_busy stall on the middle beat
        fixed_pay = '{16'h1234, 16'h5678, 16'h9ABC, 16'h0000};
        wlog.delete();
        xfer(8'h40, 8'd3, 4'd2, 0, 1'b1, 1, hc1);
        repeat (2) step();
        chk("r036_stall", stall_wait, 3);
        chk("r036_nwr", wlog.size(), 3);
        pin("r036_w0", 0, 24'h401234);
        pin("r036_w1", 1, 24'h415678);
        pin("r036_w2", 2, 24'h429ABC);

        // Reset after the first of three payload beats
        wlog.delete();
        d0 = n_done_seen;
        beat(16'h5003, 4'd2, 0, c);
        hdr_cyc = c;
        cur_own = 1'b1;
        fin_cyc = 1 << 30;
        beat(16'hDEAD, 4'd0, 0, c);
        chk("r037_we_pre", dm_we, 1);
        rst_n = 1'b0;
        #1;
        chk("r037_we", dm_we, 0);
        chk("r037_busy", busy, 0);
        chk("r037_done", done, 0);
        wq.delete();
        done_q.delete();
        drop_q.delete();
        hdr_cyc = -10;
        fin_cyc = -10;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("r037_nwr", wlog.size(), 0);
        chk("r037_nodone", n_done_seen - d0, 0);
        fixed_pay = '{16'hC0DE, 16'hF00D, 16'h0000, 16'h0000};
        xfer(8'h60, 8'd2, 4'd2, 0, 1'b1, -1, hc1);
        repeat (2) step();
        pin("r037_w0", 0, 24'h60C0DE);
        pin("r037_w1", 1, 24'h61F00D);
        chk("r037_done_after", n_done_seen - d0, 1);

        // Largest transfer
        wlog.delete();
        xfer(8'h80, 8'd255, 4'd2, 0, 1'b0, -1, hc1);
        repeat (2) step();
        chk("r027_nwr", wlog.size(), 255);
        if (wlog.size() == 255) chk("r027_last_addr", wlog[254][23:16], 8'h7E);

        // Randomized traffic
        busy_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [3:0] p;
            logic [7:0] sz;
            p  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd2;
            sz = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 40))
                                             : 8'($urandom_range(0, 6));
            xfer(8'($urandom), sz, p, 3, 1'b0, -1, hc1);
        end
        busy_rand = 1'b0;
        repeat (4) step();

        chk("end_wq_empty", wq.size(), 0);
        chk("end_done_q_empty", done_q.size(), 0);
        chk("end_drop_q_empty", drop_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
